pcm_pdm_modulator: RTL and testbench

//  Consumer end of the PCM sample-read handshake: requests 16-bit signed PCM samples from a

---
 rtl/pcm_pkg.sv | 17 +
 rtl/pcm_pdm_modulator_if.sv | 13 +
 rtl/pcm_pdm_modulator_sd_mod1.sv | 32 +++
 rtl/pcm_pdm_modulator.sv | 141 ++++++++++++++
 tb/tb_pcm_pdm_modulator.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcm_pkg.sv
// Shared constants, FSM state type and helpers for the PCM-to-PDM modulator.
package pcm_pkg;

    localparam int              PCM_W      = 16;
    localparam logic [PCM_W-1:0] PCM_OFFSET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pcm_pdm_modulator_if.sv
// PCM sample-read handshake: consumer pulses a read, source answers with ready + data.
interface pcm_pdm_modulator_if;
    import pcm_pkg::*;

    logic             pcm_read_o;
    logic             pcm_ready_i;
    logic [PCM_W-1:0] pcm_data_i;

    // master = the sample consumer (modulator), slave = the sample source
    modport master (output pcm_read_o, input  pcm_ready_i, input  pcm_data_i);
    modport slave  (input  pcm_read_o, output pcm_ready_i, output pcm_data_i);

endinterface

// File: rtl/pcm_pdm_modulator_sd_mod1.sv
// First-order sigma-delta: the carry out of a 16-bit phase accumulator is the PDM bit.
module sd_mod1
    import pcm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             step_i,
    input  logic [PCM_W-1:0] sample_i,
    output logic             bit_o
);

    logic [PCM_W-1:0] acc;
    logic [PCM_W:0]   sum;

    // Offset-binary input makes 0x8000 the all-zeros code and 0x7FFF the densest one.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, sample_i ^ PCM_OFFSET};
    end

    // NOTE: rst_n is active-high and synchronous here; it is only seen on a clock edge.
    always_ff @(posedge clk) begin
        if (rst_n || clr_i) begin
            acc   <= '0;
            bit_o <= 1'b0;
        end else if (step_i) begin
            acc   <= sum[PCM_W-1:0];
            bit_o <= sum[PCM_W];
        end
    end

endmodule

// File: rtl/pcm_pdm_modulator.sv
// PCM sample consumer with one-sample prefetch, PDM bit clock and sigma-delta modulator.
module pcm_pdm_modulator
    import pcm_pkg::*;
#(
    parameter int CLK_DIV_PDM = 4,
    parameter int OSR         = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    pcm_pdm_modulator_if.master pcm,
    output logic                pdm_clk_o,
    output logic                pdm_data_o,
    output logic                underrun_o,
    output logic [31:0]         sample_count_o
);

    localparam int DIV_W = (CLK_DIV_PDM > 1) ? $clog2(CLK_DIV_PDM) : 1;
    localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_PDM - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV_PDM / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    state_t           state;
    logic             outstanding;
    logic             nxt_valid;
    logic [PCM_W-1:0] cur;
    logic [PCM_W-1:0] nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;

    logic             step;
    logic             boundary;
    logic             accept;
    logic [DIV_W-1:0] div_nxt;

    // A ready only counts when it answers our single outstanding request.
    always_comb begin
        step     = (state == RUN) && (div_cnt == '0);
        boundary = step && (bit_cnt == BIT_LAST);
        accept   = enable_i && outstanding && pcm.pcm_ready_i;
        div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    sd_mod1 u_sd_mod1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!enable_i),
        .step_i   (step),
        .sample_i (cur),
        .bit_o    (pdm_data_o)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state          <= IDLE;
            outstanding    <= 1'b0;
            nxt_valid      <= 1'b0;
            cur            <= '0;
            nxt            <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            pcm.pcm_read_o <= 1'b0;
            pdm_clk_o      <= 1'b0;
            underrun_o     <= 1'b0;
            sample_count_o <= '0;
        end else if (!enable_i) begin
            // Stop: drop any in-flight request, keep the sticky status and the count.
            state          <= IDLE;
            outstanding    <= 1'b0;
            nxt_valid      <= 1'b0;
            nxt            <= '0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            pcm.pcm_read_o <= 1'b0;
            pdm_clk_o      <= 1'b0;
        end else begin
            pcm.pcm_read_o <= 1'b0;

            case (state)
                IDLE: begin
                    state          <= PRIME;
                    pcm.pcm_read_o <= 1'b1;
                    outstanding    <= 1'b1;
                    pdm_clk_o      <= 1'b0;
                end

                PRIME: begin
                    pdm_clk_o <= 1'b0;
                    if (accept) begin
                        cur         <= pcm.pcm_data_i;
                        outstanding <= 1'b0;
                        state       <= RUN;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        pdm_clk_o   <= 1'b1;
                    end
                end

                RUN: begin
                    div_cnt   <= div_nxt;
                    pdm_clk_o <= (div_nxt < DIV_HALF);

                    if (step) begin
                        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
                    end

                    // The boundary step still uses the old cur; the new sample starts next bit.
                    if (boundary) begin
                        if (nxt_valid) begin
                            cur       <= nxt;
                            nxt_valid <= 1'b0;
                        end else if (accept) begin
                            cur <= pcm.pcm_data_i;
                        end else begin
                            underrun_o <= 1'b1;
                        end
                    end else if (accept) begin
                        nxt       <= pcm.pcm_data_i;
                        nxt_valid <= 1'b1;
                    end

                    if (accept) begin
                        outstanding <= 1'b0;
                    end else if (!outstanding && !nxt_valid) begin
                        pcm.pcm_read_o <= 1'b1;
                        outstanding    <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase

            if (accept) begin
                sample_count_o <= sat_inc(sample_count_o);
            end
        end
    end

endmodule

// File: tb/tb_pcm_pdm_modulator.sv
// Directed bench: a source model answering reads one cycle later, a start-up vector table
// and hand-timed sequences for density, underrun, spurious ready, stop/restart and reset.
module tb_pcm_pdm_modulator;
    import pcm_pkg::*;

    localparam int DIV = 4;
    localparam int OSR = 64;

    typedef struct packed {
        logic        en;
        logic        exp_read;
        logic        exp_clk;
        logic        exp_data;
        logic [31:0] exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pdm_clk;
    logic        pdm_data;
    logic        underrun;
    logic [31:0] sample_count;

    pcm_pdm_modulator_if bus ();

    pcm_pdm_modulator #(
        .CLK_DIV_PDM (DIV),
        .OSR         (OSR)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .pcm            (bus),
        .pdm_clk_o      (pdm_clk),
        .pdm_data_o     (pdm_data),
        .underrun_o     (underrun),
        .sample_count_o (sample_count)
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          reads;
    int          dbl;
    int          exp_cnt;
    bit          pend;
    bit          resp_valid;
    bit          src_hold;
    bit          spur;
    logic [15:0] src_data;
    logic [15:0] spur_data;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then play the sample source.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.pcm_ready_i && resp_valid && enable && !rst_n) exp_cnt++;
        if (!enable || rst_n) pend = 1'b0;
        bus.pcm_ready_i = 1'b0;
        resp_valid      = 1'b0;
        if (spur) begin
            bus.pcm_ready_i = 1'b1;
            bus.pcm_data_i  = spur_data;
            spur            = 1'b0;
        end else if (pend && !src_hold) begin
            bus.pcm_ready_i = 1'b1;
            bus.pcm_data_i  = src_data;
            pend            = 1'b0;
            resp_valid      = 1'b1;
        end
        if (bus.pcm_read_o) begin
            if (pend) dbl++;
            pend = 1'b1;
            reads++;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        rst_n    = 1'b0;
        spur     = 1'b0;
        src_hold = 1'b0;
        exp_cnt  = 0;
        reads    = 0;
    endtask

    initial begin
        int ones_a;
        int ones_b;
        int clk_hi;
        int rises;
        logic bit65;
        logic prev_clk;

        n_checks = 0; n_fail = 0; cyc = 0; reads = 0; dbl = 0; exp_cnt = 0;
        pend = 1'b0; resp_valid = 1'b0; src_hold = 1'b0; spur = 1'b0;
        src_data = '0; spur_data = '0;
        bus.pcm_ready_i = 1'b0;
        bus.pcm_data_i  = '0;
        rst_n  = 1'b1;
        enable = 1'b0;

        // enable, read, clk, data, count for cycles 1..8 after enable with sample 0x0000
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd2};

        // Reset state
        do_reset();
        check("reset_read",     {31'd0, bus.pcm_read_o}, 32'd0);
        check("reset_pdm_clk",  {31'd0, pdm_clk},        32'd0);
        check("reset_pdm_data", {31'd0, pdm_data},       32'd0);
        check("reset_underrun", {31'd0, underrun},       32'd0);
        check("reset_count",    sample_count,            32'd0);

        // Start-up handshake and the first PDM bits of a 0x0000 stream
        src_data = 16'h0000;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            enable = vecs[i].en;
            tick();
            check("startup_read",  {31'd0, bus.pcm_read_o}, {31'd0, vecs[i].exp_read});
            check("startup_clk",   {31'd0, pdm_clk},        {31'd0, vecs[i].exp_clk});
            check("startup_data",  {31'd0, pdm_data},       {31'd0, vecs[i].exp_data});
            check("startup_count", sample_count,            vecs[i].exp_count);
        end

        // 0x0000 alternates 0,1 with one bit per 4 clocks; clock high for div 0,1
        for (int i = 0; i < 64; i++) begin
            int b;
            tick();
            b = (cyc - 4) / 4 + 1;
            check("mid_clk",  {31'd0, pdm_clk},  (((cyc - 3) % 4) < 2) ? 32'd1 : 32'd0);
            check("mid_data", {31'd0, pdm_data}, ((b % 2) == 0) ? 32'd1 : 32'd0);
        end

        // 0x8000 then 0x7FFF: 64 zeros, one settling zero, then 63 ones
        do_reset();
        src_data = 16'h8000;
        enable   = 1'b1;
        cyc      = 0;
        ones_a = 0; ones_b = 0; clk_hi = 0; rises = 0; bit65 = 1'b1; prev_clk = 1'b0;
        for (int i = 0; i < 515; i++) begin
            tick();
            if (cyc == 2) src_data = 16'h7FFF;
            if (cyc >= 4) begin
                if (pdm_clk) clk_hi++;
                if (pdm_clk && !prev_clk) rises++;
            end
            prev_clk = pdm_clk;
            if (cyc >= 5 && (cyc % 4) == 1) begin
                int n;
                n = (cyc - 1) / 4;
                if (n <= 64)      ones_a += int'(pdm_data);
                else if (n == 65) bit65 = pdm_data;
                else              ones_b += int'(pdm_data);
            end
        end
        check("density_8000_ones",  ones_a, 32'd0);
        check("density_first_7fff", {31'd0, bit65}, 32'd0);
        check("density_7fff_ones",  ones_b, 32'd63);
        check("pdm_clk_high",       clk_hi, 32'd256);
        check("pdm_clk_periods",    rises,  32'd128);
        check("no_underrun",        {31'd0, underrun}, 32'd0);

        // Withheld ready: bypass on a boundary, underrun, late accept, spurious ready
        do_reset();
        src_data = 16'h0000;
        enable   = 1'b1;
        cyc      = 0;
        for (int i = 0; i < 1045; i++) begin
            int n;
            n = cyc + 1;
            src_hold = (n >= 5 && n < 255) || (n >= 258 && n < 770);
            src_data = (n < 5) ? 16'h0000 : (n <= 255) ? 16'h8000 : 16'h7FFF;
            if (n == 800) begin
                spur      = 1'b1;
                spur_data = 16'h1234;
            end
            tick();
            case (cyc)
                255:  check("pre_boundary_underrun", {31'd0, underrun}, 32'd0);
                256: begin
                    check("bypass_no_underrun", {31'd0, underrun}, 32'd0);
                    check("bypass_count",       sample_count,      32'd2);
                end
                260, 264, 268, 272: check("bypass_cur", {31'd0, pdm_data}, 32'd0);
                511:  check("underrun_before", {31'd0, underrun}, 32'd0);
                512:  check("underrun_set",    {31'd0, underrun}, 32'd1);
                769: begin
                    check("held_count",  sample_count, 32'd2);
                    check("one_request", reads,        32'd3);
                end
                771:  check("late_accept", sample_count, 32'd3);
                805: begin
                    check("spur_count", sample_count,      32'd3);
                    check("spur_pdm",   {31'd0, pdm_data}, 32'd0);
                end
                1027: check("prefetch_count", sample_count, 32'd4);
                1028: check("nxt_loaded_b0", {31'd0, pdm_data}, 32'd0);
                1032, 1036, 1040: check("nxt_loaded_b1", {31'd0, pdm_data}, 32'd1);
                default: ;
            endcase
        end

        // Stop mid-sample, idle 10 cycles, restart; a ready in the stop cycle is dropped
        enable = 1'b0;
        tick();
        check("stop_clk",      {31'd0, pdm_clk},        32'd0);
        check("stop_data",     {31'd0, pdm_data},       32'd0);
        check("stop_count",    sample_count,            32'd4);
        check("stop_underrun", {31'd0, underrun},       32'd1);
        for (int i = 0; i < 9; i++) tick();
        check("idle_read", {31'd0, bus.pcm_read_o}, 32'd0);
        check("idle_clk",  {31'd0, pdm_clk},        32'd0);
        enable = 1'b1;
        tick();
        check("restart_read", {31'd0, bus.pcm_read_o}, 32'd1);
        tick();
        enable = 1'b0;
        tick();
        check("dropped_ready_count", sample_count,            32'd4);
        check("dropped_ready_read",  {31'd0, bus.pcm_read_o}, 32'd0);
        enable = 1'b1;
        tick();
        check("restart2_read", {31'd0, bus.pcm_read_o}, 32'd1);
        tick();
        tick();
        check("restart2_count", sample_count,      32'd5);
        check("restart2_run",   {31'd0, pdm_clk},  32'd1);
        check("model_count",    sample_count,      exp_cnt);
        check("single_outstanding", dbl, 32'd0);

        // Reset mid-operation clears everything, including the sticky status and count
        rst_n = 1'b1;
        tick();
        check("rerst_count",    sample_count,            32'd0);
        check("rerst_underrun", {31'd0, underrun},       32'd0);
        check("rerst_read",     {31'd0, bus.pcm_read_o}, 32'd0);
        check("rerst_clk",      {31'd0, pdm_clk},        32'd0);
        check("rerst_data",     {31'd0, pdm_data},       32'd0);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
